// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT.
// Each stage issues N/2 butterflies, then waits for the datapath write-backs to finish.
module fft_stage_sequencer #(
  parameter int N_LOG2   = 3,
  parameter int ADDR_W   = 10,
  parameter int PIPE_LAT = 2,
  localparam int TW_W    = (N_LOG2 > 1) ? N_LOG2 - 1 : 1,
  localparam int SW      = $clog2(N_LOG2 + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [TW_W-1:0]   tw_idx_o,
  output logic [SW-1:0]     stage_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o
);

  localparam int          BW = TW_W;
  localparam int          DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned PL = PIPE_LAT;

  localparam logic [BW-1:0] B_LAST = BW'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [BW-1:0]     r_bfly;
  logic [SW-1:0]     r_stage;
  logic [DW-1:0]     r_drain;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_a;
  logic [ADDR_W-1:0] r_rd_b;
  logic [TW_W-1:0]   r_tw;

  logic              r_pipe_en [PL];
  logic [ADDR_W-1:0] r_pipe_a  [PL];
  logic [ADDR_W-1:0] r_pipe_b  [PL];

  logic              w_issue;
  logic [BW-1:0]     w_nxt_bfly;
  logic [SW-1:0]     w_nxt_stage;
  logic [N_LOG2-1:0] w_bx;
  logic [N_LOG2-1:0] w_mask;
  logic [N_LOG2-1:0] w_a;
  logic [N_LOG2-1:0] w_b;
  logic [TW_W-1:0]   w_k;

  // The butterfly to issue next: continue the stage in RUN, otherwise butterfly 0
  // of stage 0 (from IDLE) or of the following stage (end of DRAIN).
  always_comb begin
    w_issue     = 1'b0;
    w_nxt_bfly  = BW'(r_bfly + 1'b1);
    w_nxt_stage = r_stage;
    case (r_state)
      S_IDLE:  w_issue = start_i;
      S_RUN:   w_issue = (r_bfly != B_LAST);
      S_DRAIN: w_issue = (r_drain == D_LAST) && (r_stage != S_LAST);
      default: w_issue = 1'b0;
    endcase
    if (r_state != S_RUN) begin
      w_nxt_bfly  = '0;
      w_nxt_stage = (r_state == S_IDLE) ? '0 : SW'(r_stage + 1'b1);
    end
  end

  // A = group base (b with bit s opened up) + position; B sits one span above A.
  always_comb begin
    w_bx   = N_LOG2'(w_nxt_bfly);
    w_mask = (N_LOG2'(1) << w_nxt_stage) - N_LOG2'(1);
    w_a    = ((w_bx & ~w_mask) << 1) | (w_bx & w_mask);
    w_b    = w_a | (N_LOG2'(1) << w_nxt_stage);
    w_k    = TW_W'(w_bx & w_mask) << (S_LAST - w_nxt_stage);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_bfly  <= '0;
      r_stage <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
      for (int unsigned i = 0; i < PL; i++) begin
        r_pipe_en[i] <= 1'b0;
        r_pipe_a[i]  <= '0;
        r_pipe_b[i]  <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_bfly  <= w_nxt_bfly;
        r_stage <= w_nxt_stage;
        r_rd_a  <= ADDR_W'(w_a);
        r_rd_b  <= ADDR_W'(w_b);
        r_tw    <= w_k;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_bfly == B_LAST) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain == D_LAST) begin
            if (r_stage == S_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_drain <= DW'(r_drain + 1'b1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      r_pipe_en[0] <= r_rd_en;
      r_pipe_a[0]  <= r_rd_a;
      r_pipe_b[0]  <= r_rd_b;
      for (int unsigned i = 1; i < PL; i++) begin
        r_pipe_en[i] <= r_pipe_en[i-1];
        r_pipe_a[i]  <= r_pipe_a[i-1];
        r_pipe_b[i]  <= r_pipe_b[i-1];
      end
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign rd_en_o     = r_rd_en;
  assign rd_addr_a_o = r_rd_a;
  assign rd_addr_b_o = r_rd_b;
  assign tw_idx_o    = r_tw;
  assign stage_o     = r_stage;
  assign wr_en_o     = r_pipe_en[PL-1];
  assign wr_addr_a_o = r_pipe_a[PL-1];
  assign wr_addr_b_o = r_pipe_b[PL-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: a run-level model queues the expected
// read/write/done events, a negedge monitor pops and compares them.
module tb_fft_stage_sequencer;

  localparam int NL  = 3;
  localparam int PL  = 2;
  localparam int AW  = 10;
  localparam int NH  = 1 << (NL - 1);
  localparam int SWD = $clog2(NL + 1);

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] ra, rb, wa, wb;
  logic [NL-2:0] tw;
  logic [SWD-1:0] stg;

  logic          rst2, start2;
  logic          busy2, done2, rd_en2, wr_en2;
  logic [3:0]    ra2, rb2, wa2, wb2;
  logic [0:0]    tw2, stg2;

  fft_stage_sequencer #(.N_LOG2(NL), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb), .tw_idx_o(tw),
    .stage_o(stg), .wr_en_o(wr_en), .wr_addr_a_o(wa), .wr_addr_b_o(wb)
  );

  fft_stage_sequencer #(.N_LOG2(1), .ADDR_W(4), .PIPE_LAT(1)) dut_small (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .rd_en_o(rd_en2), .rd_addr_a_o(ra2), .rd_addr_b_o(rb2), .tw_idx_o(tw2),
    .stage_o(stg2), .wr_en_o(wr_en2), .wr_addr_a_o(wa2), .wr_addr_b_o(wb2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int b; int k; int s; } ev_t;
  ev_t rdq[$];
  ev_t wrq[$];
  int  doneq[$];
  int  busy_lo = 1, busy_hi = 0, free_at = 0, zchk_at = -1, t0 = -1;
  int  errors = 0, checks = 0;
  bit  mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Whole run predicted from the butterfly definition: stage s occupies NH+PL cycles.
  task automatic model_start(input int t);
    for (int s = 0; s < NL; s++) begin
      for (int b = 0; b < NH; b++) begin
        ev_t e;
        int  span;
        span = 1 << s;
        e.c  = t + 1 + s * (NH + PL) + b;
        e.a  = (b / span) * 2 * span + (b % span);
        e.b  = e.a + span;
        e.k  = (b % span) * (1 << (NL - 1 - s));
        e.s  = s;
        rdq.push_back(e);
        e.c  = e.c + PL;
        wrq.push_back(e);
      end
    end
    doneq.push_back(t + NL * (NH + PL) + 1);
    busy_lo = t + 1;
    busy_hi = t + NL * (NH + PL) + 1;
    free_at = busy_hi + 1;
  endtask

  task automatic model_reset(input int r);
    ev_t keep[$];
    int  keepd[$];
    keep = {};
    foreach (rdq[i]) if (rdq[i].c <= r) keep.push_back(rdq[i]);
    rdq = keep;
    keep = {};
    foreach (wrq[i]) if (wrq[i].c <= r) keep.push_back(wrq[i]);
    wrq = keep;
    keepd = {};
    foreach (doneq[i]) if (doneq[i] <= r) keepd.push_back(doneq[i]);
    doneq = keepd;
    if (busy_hi > r) busy_hi = r;
    free_at = r + 1;
    zchk_at = r + 1;
  endtask

  // Called at posedge+1; inputs are sampled at the next posedge.
  task automatic drive(input logic st, input logic rs);
    start = st;
    rst   = rs;
    if (rs) model_reset(cyc);
    else if (st && cyc >= free_at) model_start(cyc);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      ev_t  e;
      logic exp_rd, exp_wr, exp_dn;
      exp_rd = (rdq.size() > 0) && (rdq[0].c == cyc);
      if (rd_en || exp_rd) begin
        chk("rd_en", rd_en, exp_rd);
        if (exp_rd) begin
          e = rdq.pop_front();
          if (rd_en) begin
            chk("rd_a", ra, e.a);
            chk("rd_b", rb, e.b);
            chk("tw_idx", tw, e.k);
            chk("stage", stg, e.s);
          end
        end
      end
      exp_wr = (wrq.size() > 0) && (wrq[0].c == cyc);
      if (wr_en || exp_wr) begin
        chk("wr_en", wr_en, exp_wr);
        if (exp_wr) begin
          e = wrq.pop_front();
          if (wr_en) begin
            chk("wr_a", wa, e.a);
            chk("wr_b", wb, e.b);
          end
        end
      end
      exp_dn = (doneq.size() > 0) && (doneq[0] == cyc);
      if (done || exp_dn) begin
        chk("done", done, exp_dn);
        if (exp_dn) void'(doneq.pop_front());
      end
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      if (cyc == zchk_at) begin
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_a", ra, 0);
        chk("rst_rd_b", rb, 0);
        chk("rst_wr_a", wa, 0);
        chk("rst_wr_b", wb, 0);
        chk("rst_tw", tw, 0);
        chk("rst_stage", stg, 0);
      end
    end
  end

  task automatic at_rel(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  task automatic spot_rd(input int rel, input int a, input int b, input int k, input int s);
    at_rel(rel);
    chk("spot_rd_en", rd_en, 1);
    chk("spot_rd_a", ra, a);
    chk("spot_rd_b", rb, b);
    chk("spot_tw", tw, k);
    chk("spot_stage", stg, s);
  endtask

  // Literal values from the reference trace of an 8-point run, plus the 2-point instance.
  initial begin
    wait (t0 >= 0);
    at_rel(1);
    chk("spot_busy_first", busy, 1);
    chk("small_rd_en", rd_en2, 1);
    chk("small_rd_a", ra2, 0);
    chk("small_rd_b", rb2, 1);
    chk("small_tw", tw2, 0);
    spot_rd(1, 0, 1, 0, 0);
    at_rel(2);
    chk("small_wr_en", wr_en2, 1);
    chk("small_wr_a", wa2, 0);
    chk("small_wr_b", wb2, 1);
    chk("small_rd_idle", rd_en2, 0);
    at_rel(3);
    chk("small_done", done2, 1);
    chk("small_busy", busy2, 1);
    spot_rd(4, 6, 7, 0, 0);
    at_rel(4);
    chk("small_busy_end", busy2, 0);
    chk("small_done_end", done2, 0);
    spot_rd(8, 1, 3, 2, 1);
    at_rel(9);
    chk("spot_wr_en", wr_en, 1);
    chk("spot_wr_a", wa, 0);
    chk("spot_wr_b", wb, 2);
    spot_rd(10, 5, 7, 2, 1);
    spot_rd(13, 0, 4, 0, 2);
    spot_rd(14, 1, 5, 1, 2);
    spot_rd(16, 3, 7, 3, 2);
    at_rel(18);
    chk("spot_wr_last_a", wa, 3);
    chk("spot_done_early", done, 0);
    at_rel(19);
    chk("spot_done", done, 1);
    chk("spot_busy_done", busy, 1);
    at_rel(20);
    chk("spot_busy_after", busy, 0);
  end

  initial begin
    rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) drive(1'b0, 1'b1);
    rst2   = 1'b0;
    mon_on = 1'b1;
    drive(1'b0, 1'b0);

    // Single run with a stray start pulse mid-run.
    t0     = cyc;
    start2 = 1'b1;
    drive(1'b1, 1'b0);
    start2 = 1'b0;
    repeat (4) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (17) drive(1'b0, 1'b0);

    // Reset mid-run, then a clean restart.
    drive(1'b1, 1'b0);
    repeat (7) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (22) drive(1'b0, 1'b0);

    // Reset and start together, then start held high across back-to-back runs.
    drive(1'b1, 1'b1);
    repeat (45) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);

    repeat (1500) drive($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
    repeat (25) drive(1'b0, 1'b0);

    chk("pending_rd", rdq.size(), 0);
    chk("pending_wr", wrq.size(), 0);
    chk("pending_done", doneq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
